// File: rtl/pe_mac_stream.sv
// Streaming signed MAC PE: bias + sum(act*wgt), then round/shift/relu/saturate into an ACT_W result.
// Latency: result valid 2 edges after the last beat (1 edge after start for a zero-length job).
// Backpressure: in_ready only in MAC; the result is held stable in HOLD until out_ready.
module pe_mac_stream #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int ACT_W   = 8,
    parameter int CNT_W   = 16,
    parameter int SHIFT_W = $clog2(ACC_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_len,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_round,
    input  logic                     cfg_relu,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_act,
    input  logic signed [DATA_W-1:0] in_wgt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACT_W-1:0]  out_data,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic                     sat_flag,
    output logic                     busy
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_POST, S_HOLD} state_t;

    localparam logic signed [ACC_W:0] ACT_MAX = {{(ACC_W-ACT_W+2){1'b0}}, {(ACT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACT_MIN = {{(ACC_W-ACT_W+2){1'b1}}, {(ACT_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, len_q, len_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic                      round_q, round_d, relu_q, relu_d;
    logic signed [ACT_W-1:0]   out_data_q, out_data_d;
    logic signed [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic                      sat_q, sat_d, out_valid_q, out_valid_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    p_acc;
    logic [SHIFT_W-1:0]         p_shift;
    logic                       p_round, p_relu;
    logic signed [ACC_W:0]      p_rnd, p_t, p_s;
    logic signed [ACT_W-1:0]    p_data;
    logic                       p_sat, do_load;

    assign prod     = in_act * in_wgt;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Post-processing runs on the live config/bias when a zero-length job is folded into the start cycle.
    always_comb begin
        p_acc   = (state_q == S_POST) ? acc_q   : bias;
        p_shift = (state_q == S_POST) ? shift_q : cfg_shift;
        p_round = (state_q == S_POST) ? round_q : cfg_round;
        p_relu  = (state_q == S_POST) ? relu_q  : cfg_relu;
        p_rnd   = '0;
        if (p_round && (p_shift != '0))
            p_rnd = (ACC_W+1)'(1) << (p_shift - 1'b1);
        p_t = {p_acc[ACC_W-1], p_acc} + p_rnd;
        p_s = p_t >>> p_shift;
        if (p_relu && p_s[ACC_W])
            p_s = '0;
        p_sat  = 1'b0;
        p_data = p_s[ACT_W-1:0];
        if (p_s > ACT_MAX) begin
            p_sat  = 1'b1;
            p_data = ACT_MAX[ACT_W-1:0];
        end else if (p_s < ACT_MIN) begin
            p_sat  = 1'b1;
            p_data = ACT_MIN[ACT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        shift_d     = shift_q;
        round_d     = round_q;
        relu_d      = relu_q;
        out_data_d  = out_data_q;
        out_acc_d   = out_acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        do_load     = 1'b0;

        case (state_q)
            S_IDLE: do_load = start;
            S_MAC: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1)
                        state_d = S_POST;
                end
            end
            S_POST: begin
                out_data_d  = p_data;
                out_acc_d   = acc_q;
                sat_d       = p_sat;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) do_load = 1'b1;
                    else       state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_load) begin
            len_d   = cfg_len;
            shift_d = cfg_shift;
            round_d = cfg_round;
            relu_d  = cfg_relu;
            acc_d   = bias;
            cnt_d   = '0;
            if (cfg_len != '0) begin
                state_d = S_MAC;
            end else begin
                out_data_d  = p_data;
                out_acc_d   = bias;
                sat_d       = p_sat;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
        end

        if (clear) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            round_q     <= 1'b0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            out_acc_q   <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            round_q     <= round_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            out_acc_q   <= out_acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_MAC);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_acc   = out_acc_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench for pe_mac_stream: hand-computed dot products, latency, hold, clear and reset cases.
module tb_pe_mac_stream;
    logic               clk = 1'b0;
    logic               reset, clear, start, cfg_round, cfg_relu;
    logic [15:0]        cfg_len;
    logic [4:0]         cfg_shift;
    logic signed [31:0] bias;
    logic               in_valid, in_ready, out_valid, out_ready, sat_flag, busy;
    logic signed [7:0]  in_act, in_wgt, out_data;
    logic signed [31:0] out_acc;

    int n_chk  = 0;
    int n_pass = 0;

    pe_mac_stream dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start),
        .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_round(cfg_round), .cfg_relu(cfg_relu),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_acc(out_acc),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives start for one edge, then scrambles config/bias to show it is not re-sampled.
    task automatic start_job(input int len, input int b, input int sh, input bit rnd, input bit rl);
        cfg_len = 16'(len); bias = b; cfg_shift = 5'(sh); cfg_round = rnd; cfg_relu = rl;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_len = 16'd7; bias = 32'sd12345; cfg_shift = 5'd9; cfg_round = ~rnd; cfg_relu = ~rl;
    endtask

    task automatic send_beat(input int a, input int w);
        int n;
        in_valid = 1'b1; in_act = 8'(a); in_wgt = 8'(w);
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20) check("beat_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int d, input int acc, input bit sat);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_acc"}, out_acc, acc);
        check({tag, "_sat"}, sat_flag, sat);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_len = '0; cfg_shift = '0; cfg_round = 1'b0; cfg_relu = 1'b0; bias = '0;
        in_act = '0; in_wgt = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_sat", sat_flag, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // 10 + 6 - 20 + 7 = 3, with a two-cycle stall between beats
        start_job(3, 10, 0, 0, 0);
        check("t1_in_ready", in_ready, 1);
        check("t1_busy", busy, 1);
        send_beat(2, 3);
        step(); step();
        check("t1_stall_ready", in_ready, 1);
        send_beat(-4, 5);
        send_beat(7, 1);
        check("t1_ready_after_last", in_ready, 0);
        check("t1_valid_early", out_valid, 0);
        step();
        check_out("t1", 3, 3, 0);
        drain();
        check("t1_valid_drop", out_valid, 0);
        check("t1_idle", busy, 0);

        // 16129 + 8 = 16137 >>> 4 = 1008 -> saturates to 127
        start_job(1, 0, 4, 1, 0);
        send_beat(127, 127);
        step();
        check_out("t2", 127, 16129, 1);
        drain();

        // -30 with relu -> 0; without relu, (-30 + 2) >>> 2 = -7
        start_job(1, 0, 0, 0, 1);
        send_beat(-5, 6);
        step();
        check_out("t3a", 0, -30, 0);
        drain();
        start_job(1, 0, 2, 1, 0);
        send_beat(-5, 6);
        step();
        check_out("t3b", -7, -30, 0);
        drain();

        // zero-length job: result straight from bias one edge after start
        start_job(0, -300, 0, 0, 0);
        check("t4_in_ready", in_ready, 0);
        check_out("t4", -128, -300, 1);
        drain();

        // hold stability, ignored start, then back-to-back start on the draining edge
        start_job(1, 0, 0, 0, 0);
        send_beat(3, 4);
        step();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_data", out_data, 12);
            check("t5_hold_ready", in_ready, 0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        start_job(2, 100, 0, 0, 0);
        out_ready = 1'b0;
        check("t5_b2b_valid", out_valid, 0);
        check("t5_b2b_ready", in_ready, 1);
        send_beat(2, 2);
        send_beat(-3, 3);
        step();
        check_out("t5", 95, 95, 0);
        drain();

        // clear after one of three beats, in_valid stuck high
        start_job(3, 0, 0, 0, 0);
        in_valid = 1'b1; in_act = 8'sd1; in_wgt = 8'sd1;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t6_clear_ready", in_ready, 0);
        check("t6_clear_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        start_job(1, 5, 0, 0, 0);
        send_beat(1, 1);
        step();
        check_out("t6", 6, 6, 0);
        drain();

        // asynchronous reset mid-job
        start_job(3, 0, 0, 0, 0);
        in_valid = 1'b1; in_act = 8'sd1; in_wgt = 8'sd1;
        step();
        reset = 1'b0;
        #1;
        check("t7_rst_ready", in_ready, 0);
        check("t7_rst_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t7_no_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        start_job(1, 5, 0, 0, 0);
        send_beat(1, 1);
        step();
        check_out("t7", 6, 6, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
